fft_input_framer: RTL and testbench

FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_frame_bank.sv | 37 +++
 rtl/fft_input_framer.sv | 136 +++++++++++++
 tb/tb_fft_input_framer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame length/width, fixed-point fraction
// bits, complex sample type, framer FSM states and the bit-reversal helper.
// Latency/backpressure: n/a (declarations only).
package fft_pkg;

  localparam int N    = 16;
  localparam int W    = 16;
  localparam int FRAC = 8;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fr_state_t;

  // Reverse the low 'bits' bits of k; bits above 'bits' come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[bits-1-i] = k[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry complex register bank: single indexed write port, all entries
// visible in parallel. Latency: write lands one cycle after we. No backpressure.
// Ports: clk, rst_n (sync, active-low, clears all entries), we, idx,
//        wr_real/wr_im (write data), rd_real/rd_im (parallel contents).
module fft_frame_bank #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] idx,
  input  logic signed [W-1:0]  wr_real,
  input  logic signed [W-1:0]  wr_im,
  output logic signed [W-1:0]  rd_real [0:N-1],
  output logic signed [W-1:0]  rd_im   [0:N-1]
);

  logic signed [W-1:0] mem_real [0:N-1];
  logic signed [W-1:0] mem_im   [0:N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_real[i] <= '0;
        mem_im[i]   <= '0;
      end
    end else if (we) begin
      mem_real[idx] <= wr_real;
      mem_im[idx]   <= wr_im;
    end
  end

  assign rd_real = mem_real;
  assign rd_im   = mem_im;

endmodule

// File: rtl/fft_input_framer.sv
// Collects N streamed complex samples into a parallel frame for the FFT using
// ping-pong banks. Latency: m_valid one cycle after the Nth accept (bank free).
// Backpressure: s_ready drops only when the fill bank is full and output busy.
// Ports: clk, rst_n (sync, active-low); s_valid/s_ready/s_real/s_im/s_last
//        sample input; m_valid/m_ready frame handshake; x_real/x_im parallel
//        frame; frame_err one-cycle pulse on s_last misalignment.
// Build option: define FFT_FRAMER_BITREV_EN to store sample k at bitrev(k).
module fft_input_framer #(
  parameter int N = fft_pkg::N,
  parameter int W = fft_pkg::W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_real,
  input  logic signed [W-1:0] s_im,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] x_real [0:N-1],
  output logic signed [W-1:0] x_im   [0:N-1],
  output logic                frame_err
);

  import fft_pkg::*;

  localparam int IW = $clog2(N);

  fr_state_t     state;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] wr_pos;
  logic          fill_sel;   // 0: bank A fills, bank B is presented
  logic          acc;
  logic          hs;
  logic          last_idx;
  cplx_t         smp;

  logic signed [W-1:0] a_real [0:N-1];
  logic signed [W-1:0] a_im   [0:N-1];
  logic signed [W-1:0] b_real [0:N-1];
  logic signed [W-1:0] b_im   [0:N-1];

  assign smp.re   = s_real;
  assign smp.im   = s_im;
  assign acc      = s_valid && s_ready;
  assign hs       = m_valid && m_ready;
  assign last_idx = (wr_idx == IW'(N-1));

  always_comb begin
`ifdef FFT_FRAMER_BITREV_EN
    wr_pos = IW'(bitrev(32'(wr_idx), IW));
`else
    wr_pos = wr_idx;
`endif
  end

  fft_frame_bank #(.N(N), .W(W)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (acc && !fill_sel),
    .idx     (wr_pos),
    .wr_real (smp.re),
    .wr_im   (smp.im),
    .rd_real (a_real),
    .rd_im   (a_im)
  );

  fft_frame_bank #(.N(N), .W(W)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (acc && fill_sel),
    .idx     (wr_pos),
    .wr_real (smp.re),
    .wr_im   (smp.im),
    .rd_real (b_real),
    .rd_im   (b_im)
  );

  // The output always shows whichever bank is not being filled.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_real[i] = fill_sel ? a_real[i] : b_real[i];
      x_im[i]   = fill_sel ? a_im[i]   : b_im[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_idx    <= '0;
      fill_sel  <= 1'b0;
      m_valid   <= 1'b0;
      s_ready   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && (s_last != last_idx);
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (acc) begin
            wr_idx <= last_idx ? '0 : wr_idx + 1'b1;
          end
          if (acc && last_idx) begin
            // A handshake in this same cycle frees the output bank, so the
            // swap happens now and m_valid stays high without a gap.
            if (!m_valid || m_ready) begin
              fill_sel <= ~fill_sel;
              m_valid  <= 1'b1;
            end else begin
              state   <= HOLD;
              s_ready <= 1'b0;
            end
          end else if (hs) begin
            m_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (hs) begin
            fill_sel <= ~fill_sel;
            m_valid  <= 1'b1;
            state    <= FILL;
            s_ready  <= 1'b1;
          end else begin
            s_ready <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer (N=16, W=16). Expected values are
// hand-computed constants; bit-reversed expectations apply when
// FFT_FRAMER_BITREV_EN is defined.
module tb_fft_input_framer;

  logic               clk;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_real;
  logic signed [15:0] s_im;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] x_real [0:15];
  logic signed [15:0] x_im   [0:15];
  logic               frame_err;

  int passed = 0;
  int total  = 0;

  fft_input_framer #(.N(16), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_real    (s_real),
    .s_im      (s_im),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .x_real    (x_real),
    .x_im      (x_im),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the sample until it is accepted; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    s_valid = 1'b1;
    s_real  = re;
    s_im    = im;
    s_last  = last;
    while (!took && n < 64) begin
      took = s_ready;
      step();
      n++;
    end
    chk("send_accept", {15'd0, took}, 16'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_real  = '0;
    s_im    = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_s_ready", {15'd0, s_ready}, 16'd0);
    chk("rst_m_valid", {15'd0, m_valid}, 16'd0);
    chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
    chk("rst_x_real0", x_real[0], 16'h0000);
    rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", {15'd0, s_ready}, 16'd1);

    // Sixteen samples of 1.0 with m_ready high
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(16'h0100, 16'h0000, k == 15);
      if (k == 14) chk("ones_m_valid_early", {15'd0, m_valid}, 16'd0);
    end
    chk("ones_m_valid", {15'd0, m_valid}, 16'd1);
    chk("ones_frame_err", {15'd0, frame_err}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ones_x_real%0d", i), x_real[i], 16'h0100);
      chk($sformatf("ones_x_im%0d", i), x_im[i], 16'h0000);
    end
    s_valid = 1'b0;
    step();
    chk("ones_consumed", {15'd0, m_valid}, 16'd0);

    // Ramp frame, held by m_ready low
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send(16'(k * 256), 16'(k), k == 15);
    end
    chk("ramp_m_valid", {15'd0, m_valid}, 16'd1);
`ifdef FFT_FRAMER_BITREV_EN
    chk("ramp_x_real1", x_real[1], 16'h0800);
    chk("ramp_x_real8", x_real[8], 16'h0100);
    chk("ramp_x_im3", x_im[3], 16'h000C);
`else
    chk("ramp_x_real1", x_real[1], 16'h0100);
    chk("ramp_x_real8", x_real[8], 16'h0800);
    chk("ramp_x_im3", x_im[3], 16'h0003);
`endif
    chk("ramp_x_real15", x_real[15], 16'h0F00);

    // Second frame fills while the ramp is still held, then HOLD
    for (int k = 0; k < 16; k++) begin
      send(16'(16'h1000 + k), 16'hFF00, k == 15);
    end
    chk("hold_s_ready", {15'd0, s_ready}, 16'd0);
    chk("hold_m_valid", {15'd0, m_valid}, 16'd1);
`ifdef FFT_FRAMER_BITREV_EN
    chk("hold_x_real1_stable", x_real[1], 16'h0800);
`else
    chk("hold_x_real1_stable", x_real[1], 16'h0100);
`endif
    s_valid = 1'b1;
    s_real  = 16'h2000;
    s_im    = 16'h0000;
    s_last  = 1'b0;
    step();
    step();
    step();
    chk("hold_s_ready_still", {15'd0, s_ready}, 16'd0);
    m_ready = 1'b1;
    step();
    chk("swap_m_valid", {15'd0, m_valid}, 16'd1);
    chk("swap_s_ready", {15'd0, s_ready}, 16'd1);
    chk("swap_x_real0", x_real[0], 16'h1000);
    chk("swap_x_real15", x_real[15], 16'h100F);
`ifdef FFT_FRAMER_BITREV_EN
    chk("swap_x_real1", x_real[1], 16'h1008);
`else
    chk("swap_x_real1", x_real[1], 16'h1001);
`endif
    chk("swap_x_im7", x_im[7], 16'hFF00);
    m_ready = 1'b0;

    // 16th accept coincides with the output handshake
    for (int k = 0; k < 16; k++) begin
      send(16'(16'h2000 + k), 16'h0000, k == 15);
      if (k == 14) begin
        chk("coin_old_x_real0", x_real[0], 16'h1000);
        m_ready = 1'b1;
      end
    end
    chk("coin_m_valid", {15'd0, m_valid}, 16'd1);
    chk("coin_x_real0", x_real[0], 16'h2000);
    chk("coin_x_real15", x_real[15], 16'h200F);
    s_valid = 1'b0;
    step();
    chk("coin_consumed", {15'd0, m_valid}, 16'd0);

    // Reset mid-frame discards the partial frame
    for (int k = 0; k < 7; k++) begin
      send(16'h0700, 16'h0000, 1'b0);
    end
    rst_n   = 1'b0;
    s_valid = 1'b0;
    step();
    chk("midrst_m_valid", {15'd0, m_valid}, 16'd0);
    chk("midrst_s_ready", {15'd0, s_ready}, 16'd0);
    chk("midrst_x_real5", x_real[5], 16'h0000);
    rst_n   = 1'b1;
    m_ready = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      send(16'h0200, 16'h0000, k == 15);
      if (k == 8) chk("midrst_no_early_frame", {15'd0, m_valid}, 16'd0);
    end
    chk("midrst_frame_m_valid", {15'd0, m_valid}, 16'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("midrst_x_real%0d", i), x_real[i], 16'h0200);
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    step();
    chk("midrst_consumed", {15'd0, m_valid}, 16'd0);

    // Misplaced s_last on sample 5
    for (int k = 0; k < 16; k++) begin
      send(16'h0300, 16'h0000, k == 5);
      if (k == 4) chk("err_before", {15'd0, frame_err}, 16'd0);
      if (k == 5) chk("err_pulse", {15'd0, frame_err}, 16'd1);
      if (k == 6) chk("err_one_cycle", {15'd0, frame_err}, 16'd0);
    end
    chk("err_frame_done", {15'd0, m_valid}, 16'd1);
    chk("err_missing_last", {15'd0, frame_err}, 16'd1);
    s_valid = 1'b0;
    step();
    chk("err_clear", {15'd0, frame_err}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
